// File: rtl/ipf_pkg.sv
// ipf_pkg: definitions shared by the IPF feeder and its read-alignment pipe.
//   - ctrl tag encodings (END/START/HOLD)
//   - Wsize encodings and the per-kernel weight / lead-in word counts
//   - feeder state enum
//   - per-word side-band tag struct and the rule that fills it in
package ipf_pkg;

  typedef enum logic [1:0] {
    CTRL_END   = 2'd0,
    CTRL_START = 2'd1,
    CTRL_HOLD  = 2'd2
  } ctrl_e;

  localparam logic [1:0] WSIZE_3X3 = 2'd0;
  localparam logic [1:0] WSIZE_5X5 = 2'd1;

  // Weight words per block and HOLD lead-in words per pass.
  localparam int unsigned NW_3X3   = 18;
  localparam int unsigned NW_5X5   = 25;
  localparam int unsigned LEAD_3X3 = 2;
  localparam int unsigned LEAD_5X5 = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WLOAD,
    ST_PASS,
    ST_ENDW
  } state_e;

  // Side-band fields that travel alongside each input word.
  typedef struct packed {
    ctrl_e      ctrl;
    logic [3:0] wgroup;
    logic [2:0] wround;
  } ipf_tag_t;

  localparam ipf_tag_t TAG_RESET = '{ctrl: CTRL_HOLD, wgroup: 4'd0, wround: 3'd0};
  localparam ipf_tag_t TAG_END   = '{ctrl: CTRL_END,  wgroup: 4'd0, wround: 3'd0};

  // Tag for input word `word` of pass `pass_idx`.
  function automatic ipf_tag_t word_tag(input logic        is_5x5,
                                        input logic        stride2,
                                        input logic [3:0]  pass_idx,
                                        input int unsigned word);
    ipf_tag_t t;
    logic     hold;
    hold     = word < (is_5x5 ? LEAD_5X5 : LEAD_3X3);
    t.ctrl   = hold ? CTRL_HOLD : CTRL_START;
    t.wround = 3'd0;
    if (is_5x5) begin
      // 5x5 kernels are split over two rounds per weight group.
      t.wround = {2'b00, pass_idx[0]};
      t.wgroup = {1'b0, pass_idx[3:1]};
    end else if (stride2) begin
      // Stride 2 alternates the two column phases on START words.
      t.wgroup = {3'b000, ~hold & word[0]};
    end else begin
      t.wgroup = pass_idx;
    end
    return t;
  endfunction

endpackage

// File: rtl/ipf_rd_align.sv
// ipf_rd_align: 2-stage alignment pipe for one synchronous-memory read path.
//   Stage 1 tracks the memory cycle (valid/tag only, data is still inside the
//   memory); stage 2 registers the returned word, so valid_o/data_o/tag_o
//   appear exactly two cycles after rd_i.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   rd_i          read issued this cycle
//   tag_ld_i      tag_i should be presented (may be set without a read)
//   tag_i         side-band tag for this slot
//   rdata_i       memory read data (valid the cycle after rd_i)
//   valid_o       aligned data valid
//   data_o        aligned data (holds last value between reads)
//   tag_o         aligned tag (holds until the next loaded slot)
//   busy_o        a slot is still somewhere in the pipe
module ipf_rd_align #(
  parameter int              DATA_W  = 64,
  parameter int              TAG_W   = 1,
  parameter logic [TAG_W-1:0] TAG_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_i,
  input  logic              tag_ld_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              busy_o
);

  logic              v1_q;
  logic              ld1_q;
  logic [TAG_W-1:0]  tag1_q;
  logic              v2_q;
  logic [DATA_W-1:0] data2_q;
  logic [TAG_W-1:0]  tag2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the data word is a single output register, not a storage array,
      // so it is reset like every other output to give a clean 0 after reset.
      v1_q    <= 1'b0;
      ld1_q   <= 1'b0;
      tag1_q  <= TAG_RST;
      v2_q    <= 1'b0;
      data2_q <= '0;
      tag2_q  <= TAG_RST;
    end else begin
      v1_q   <= rd_i;
      ld1_q  <= tag_ld_i;
      tag1_q <= tag_i;
      v2_q   <= v1_q;
      if (v1_q)  data2_q <= rdata_i;
      if (ld1_q) tag2_q  <= tag1_q;
    end
  end

  assign valid_o = v2_q;
  assign data_o  = data2_q;
  assign tag_o   = tag2_q;
  assign busy_o  = v1_q | ld1_q | v2_q;

endmodule

// File: rtl/ipf_feeder.sv
// ipf_feeder: sequencer feeding the IPF multiply engine.
//   On start it reads a weight block (18 or 25 words) and then P passes of an
//   I_WORDS input tile, streaming them to IPF with per-word ctrl/wgroup/wround
//   tags, then issues END and waits for IPF finish before pulsing done.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   start                     job request (ignored while busy)
//   cfg_wsize/stride/passes   job configuration, captured on start
//   cfg_w_base/cfg_i_base     memory base addresses
//   w_rd/w_addr/w_rdata       weight memory read port
//   i_rd/i_addr/i_rdata       input memory read port
//   w_valid/w_data            weight stream to IPF
//   i_valid/i_data            input stream to IPF
//   ctrl/Wsize/stride         IPF control side-band
//   wgroup/wround             IPF per-word weight selection
//   ipf_finish                IPF finish
//   busy/done                 job status
module ipf_feeder
  import ipf_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 16,
  parameter int I_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        cfg_wsize,
  input  logic              cfg_stride,
  input  logic [3:0]        cfg_passes,
  input  logic [ADDR_W-1:0] cfg_w_base,
  input  logic [ADDR_W-1:0] cfg_i_base,
  output logic              w_rd,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_rdata,
  output logic              i_rd,
  output logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              w_valid,
  output logic [DATA_W-1:0] w_data,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_data,
  output logic [1:0]        ctrl,
  output logic [1:0]        Wsize,
  output logic              stride,
  output logic [3:0]        wgroup,
  output logic [2:0]        wround,
  input  logic              ipf_finish,
  output logic              busy,
  output logic              done
);

  localparam int J_W = (I_WORDS > 1) ? $clog2(I_WORDS) : 1;
  localparam int TAG_W = $bits(ipf_tag_t);

  state_e            state_q;
  logic [1:0]        wsize_q;
  logic              stride_q;
  logic [3:0]        passes_q;
  logic [ADDR_W-1:0] i_base_q;
  logic [4:0]        k_q;
  logic [J_W-1:0]    j_q;
  logic [3:0]        p_q;
  logic              w_rd_q;
  logic [ADDR_W-1:0] w_addr_q;
  logic              i_rd_q;
  logic [ADDR_W-1:0] i_addr_q;
  logic              end_ld_q;
  logic              busy_q;
  logic              done_q;

  logic     is_5x5;
  logic     last_w;
  logic     last_j;
  logic     last_p;
  logic     drained;
  logic     w_busy;
  logic     i_busy;
  logic     w_tag_unused;
  ipf_tag_t i_tag_in;
  ipf_tag_t i_tag_out;

  assign is_5x5 = (wsize_q == WSIZE_5X5);
  assign last_w = (k_q == (is_5x5 ? 5'(NW_5X5 - 1) : 5'(NW_3X3 - 1)));
  assign last_j = (j_q == J_W'(I_WORDS - 1));
  assign last_p = (p_q == passes_q - 4'd1);
  // finish only counts once the last input word and the END slot have left.
  assign drained = ~(w_busy | i_busy);

  // The END slot rides the input pipe so ctrl flips with the i_valid drop.
  assign i_tag_in = end_ld_q ? TAG_END
                             : word_tag(is_5x5, stride_q, p_q, 32'(j_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      wsize_q  <= WSIZE_3X3;
      stride_q <= 1'b0;
      passes_q <= 4'd1;
      i_base_q <= '0;
      k_q      <= '0;
      j_q      <= '0;
      p_q      <= '0;
      w_rd_q   <= 1'b0;
      w_addr_q <= '0;
      i_rd_q   <= 1'b0;
      i_addr_q <= '0;
      end_ld_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: every state register uses <= so all of them see the values from
      // before this edge, regardless of statement order below.
      done_q   <= 1'b0;
      end_ld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            wsize_q  <= (cfg_wsize == WSIZE_5X5) ? WSIZE_5X5 : WSIZE_3X3;
            stride_q <= cfg_stride;
            passes_q <= (cfg_passes == 4'd0) ? 4'd1 : cfg_passes;
            i_base_q <= cfg_i_base;
            w_addr_q <= cfg_w_base;
            w_rd_q   <= 1'b1;
            k_q      <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_WLOAD;
          end
        end
        ST_WLOAD: begin
          if (last_w) begin
            // Hand straight over to the input reads: no bubble in the stream.
            w_rd_q   <= 1'b0;
            i_rd_q   <= 1'b1;
            i_addr_q <= i_base_q;
            j_q      <= '0;
            p_q      <= '0;
            state_q  <= ST_PASS;
          end else begin
            k_q      <= k_q + 5'd1;
            w_addr_q <= w_addr_q + ADDR_W'(1);
          end
        end
        ST_PASS: begin
          if (last_j) begin
            if (last_p) begin
              i_rd_q   <= 1'b0;
              end_ld_q <= 1'b1;
              state_q  <= ST_ENDW;
            end else begin
              p_q      <= p_q + 4'd1;
              j_q      <= '0;
              i_addr_q <= i_base_q;
            end
          end else begin
            j_q      <= j_q + J_W'(1);
            i_addr_q <= i_addr_q + ADDR_W'(1);
          end
        end
        ST_ENDW: begin
          if (drained && ipf_finish) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  ipf_rd_align #(
    .DATA_W (DATA_W),
    .TAG_W  (1),
    .TAG_RST(1'b0)
  ) u_w_align (
    .clk     (clk),
    .rst     (rst),
    .rd_i    (w_rd_q),
    .tag_ld_i(w_rd_q),
    .tag_i   (1'b0),
    .rdata_i (w_rdata),
    .valid_o (w_valid),
    .data_o  (w_data),
    .tag_o   (w_tag_unused),
    .busy_o  (w_busy)
  );

  ipf_rd_align #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .TAG_RST(TAG_RESET)
  ) u_i_align (
    .clk     (clk),
    .rst     (rst),
    .rd_i    (i_rd_q),
    .tag_ld_i(i_rd_q | end_ld_q),
    .tag_i   (i_tag_in),
    .rdata_i (i_rdata),
    .valid_o (i_valid),
    .data_o  (i_data),
    .tag_o   (i_tag_out),
    .busy_o  (i_busy)
  );

  assign w_rd   = w_rd_q;
  assign w_addr = w_addr_q;
  assign i_rd   = i_rd_q;
  assign i_addr = i_addr_q;
  assign ctrl   = i_tag_out.ctrl;
  assign wgroup = i_tag_out.wgroup;
  assign wround = i_tag_out.wround;
  assign Wsize  = wsize_q;
  assign stride = stride_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_ipf_feeder.sv
// tb_ipf_feeder: scoreboard bench for ipf_feeder. The stimulus side builds
// the expected weight/input streams from the job configuration and queues
// them; a negedge monitor pops and compares whenever the DUT shows valid.
module tb_ipf_feeder;
  import ipf_pkg::*;

  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 16;
  localparam int I_WORDS = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        cfg_wsize = '0;
  logic              cfg_stride = 1'b0;
  logic [3:0]        cfg_passes = '0;
  logic [ADDR_W-1:0] cfg_w_base = '0;
  logic [ADDR_W-1:0] cfg_i_base = '0;
  logic              w_rd, i_rd;
  logic [ADDR_W-1:0] w_addr, i_addr;
  logic [DATA_W-1:0] w_rdata = '0, i_rdata = '0;
  logic              w_valid, i_valid;
  logic [DATA_W-1:0] w_data, i_data;
  logic [1:0]        ctrl, Wsize;
  logic              stride;
  logic [3:0]        wgroup;
  logic [2:0]        wround;
  logic              ipf_finish = 1'b0;
  logic              busy, done;

  always #5 clk = ~clk;

  ipf_feeder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .I_WORDS(I_WORDS)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_wsize(cfg_wsize), .cfg_stride(cfg_stride), .cfg_passes(cfg_passes),
    .cfg_w_base(cfg_w_base), .cfg_i_base(cfg_i_base),
    .w_rd(w_rd), .w_addr(w_addr), .w_rdata(w_rdata),
    .i_rd(i_rd), .i_addr(i_addr), .i_rdata(i_rdata),
    .w_valid(w_valid), .w_data(w_data), .i_valid(i_valid), .i_data(i_data),
    .ctrl(ctrl), .Wsize(Wsize), .stride(stride), .wgroup(wgroup), .wround(wround),
    .ipf_finish(ipf_finish), .busy(busy), .done(done)
  );

  // Memory contents as functions of address; the two memories differ.
  function automatic logic [63:0] w_fn(input logic [15:0] a);
    return {16'hC0DE, 16'(a * 16'd7), 16'h0000, a};
  endfunction
  function automatic logic [63:0] i_fn(input logic [15:0] a);
    return 64'(a) + 64'hA0;
  endfunction

  // Synchronous memories; junk when not read so stale data is visible.
  always @(posedge clk) begin
    w_rdata <= w_rd ? w_fn(w_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
    i_rdata <= i_rd ? i_fn(i_addr) : 64'hDEAD_DEAD_DEAD_DEAD;
  end

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  ctrl;
    logic [3:0]  wgroup;
    logic [2:0]  wround;
  } iexp_t;

  logic [63:0] w_q[$];
  iexp_t       i_q[$];
  int          len_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          exp_done = 0;
  int          done_seen = 0;
  int          streams_done = 0;
  int          i_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Monitor: compares every presented word against the scoreboard.
  logic [1:0] wrd_h = '0, ird_h = '0;
  bit         streaming = 0;
  int         stream_len = 0;
  always @(negedge clk) begin : mon
    iexp_t e;
    if (!rst) begin
      wrd_h = '0;
      ird_h = '0;
      streaming = 0;
      stream_len = 0;
    end else begin
      if (w_valid || wrd_h[1]) check("w_latency", w_valid, wrd_h[1]);
      if (i_valid || ird_h[1]) check("i_latency", i_valid, ird_h[1]);
      wrd_h = {wrd_h[0], w_rd};
      ird_h = {ird_h[0], i_rd};
      if (w_valid) begin
        if (w_q.size() == 0) fail_now("w_extra_word");
        else check("w_data", w_data, w_q.pop_front());
      end
      if (i_valid) begin
        i_seen++;
        if (i_q.size() == 0) fail_now("i_extra_word");
        else begin
          e = i_q.pop_front();
          check("i_data", i_data, e.data);
          check("ctrl", ctrl, e.ctrl);
          check("wgroup", wgroup, e.wgroup);
          check("wround", wround, e.wround);
        end
      end
      if (w_valid || i_valid) begin
        streaming = 1;
        stream_len++;
      end else if (streaming) begin
        streaming = 0;
        if (len_q.size() == 0) fail_now("stream_unexpected");
        else check("stream_len", stream_len, len_q.pop_front());
        check("ctrl_end", ctrl, CTRL_END);
        stream_len = 0;
        streams_done++;
      end
      if (done) done_seen++;
    end
  end

  // Reference model: expected streams straight from the job rules.
  task automatic push_expect(input logic [1:0] ws, input logic st, input logic [3:0] ps,
                             input logic [15:0] wb, input logic [15:0] ib);
    int    nw, lead, np;
    iexp_t e;
    nw   = (ws == 2'd1) ? 25 : 18;
    lead = (ws == 2'd1) ? 4 : 2;
    np   = (ps == 4'd0) ? 1 : int'(ps);
    for (int k = 0; k < nw; k++) w_q.push_back(w_fn(16'(wb + k)));
    for (int p = 0; p < np; p++) begin
      for (int j = 0; j < I_WORDS; j++) begin
        e.data = i_fn(16'(ib + j));
        e.ctrl = (j < lead) ? CTRL_HOLD : CTRL_START;
        if (ws == 2'd1) begin
          e.wround = 3'(p % 2);
          e.wgroup = 4'(p / 2);
        end else if (st) begin
          e.wround = 3'd0;
          e.wgroup = (j < lead) ? 4'd0 : 4'(j % 2);
        end else begin
          e.wround = 3'd0;
          e.wgroup = 4'(p);
        end
        i_q.push_back(e);
      end
    end
    len_q.push_back(nw + np * I_WORDS);
  endtask

  task automatic pulse_start(input logic [1:0] ws, input logic st, input logic [3:0] ps,
                             input logic [15:0] wb, input logic [15:0] ib);
    cfg_wsize = ws; cfg_stride = st; cfg_passes = ps;
    cfg_w_base = wb; cfg_i_base = ib;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_rise", busy, 1);
    check("w_rd_first", w_rd, 1);
    check("w_addr_first", w_addr, wb);
    check("stride_out", stride, st);
    if (ws < 2'd2) check("wsize_out", Wsize, ws);
  endtask

  task automatic run_job(input logic [1:0] ws, input logic st, input logic [3:0] ps,
                         input logic [15:0] wb, input logic [15:0] ib);
    int nw, s0, guard;
    nw = (ws == 2'd1) ? 25 : 18;
    s0 = streams_done;
    push_expect(ws, st, ps, wb, ib);
    pulse_start(ws, st, ps, wb, ib);
    // A start while busy (new random config) and an early finish mid-pass.
    for (int c = 1; c < nw + 4; c++) begin
      @(posedge clk); #1;
      start = (c == 3);
      if (c == 3) begin
        cfg_wsize = 2'($urandom_range(3, 0));
        cfg_stride = 1'($urandom_range(1, 0));
        cfg_passes = 4'($urandom_range(15, 0));
        cfg_w_base = 16'($urandom);
        cfg_i_base = 16'($urandom);
      end
      ipf_finish = (c == nw + 2);
    end
    start = 1'b0;
    ipf_finish = 1'b0;
    guard = 0;
    while (streams_done == s0 && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (streams_done == s0) fail_now("stream_timeout");
    check("no_early_done", done, 0);
    check("busy_in_endw", busy, 1);
    repeat ($urandom_range(3, 0)) @(posedge clk);
    #1;
    ipf_finish = 1'b1;
    @(posedge clk); #1;
    ipf_finish = 1'b0;
    exp_done++;
    check("done_pulse", done, 1);
    check("busy_fall", busy, 0);
    check("w_q_empty", w_q.size(), 0);
    check("i_q_empty", i_q.size(), 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
  endtask

  task automatic reset_mid_job();
    int s0, guard;
    s0 = i_seen;
    push_expect(2'd0, 1'b0, 4'd3, 16'h0100, 16'h0200);
    pulse_start(2'd0, 1'b0, 4'd3, 16'h0100, 16'h0200);
    guard = 0;
    while (i_seen - s0 < 10 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (i_seen - s0 < 10) fail_now("reset_wait_timeout");
    rst = 1'b0;
    #1;
    check("rst_ctrl", ctrl, CTRL_HOLD);
    check("rst_i_valid", i_valid, 0);
    check("rst_w_valid", w_valid, 0);
    check("rst_i_data", i_data, 0);
    check("rst_busy", busy, 0);
    check("rst_rd", {w_rd, i_rd}, 0);
    check("rst_wgroup", wgroup, 0);
    w_q.delete();
    i_q.delete();
    len_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_done", done, 0);
    check("rst_idle_busy", busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", ctrl, CTRL_HOLD);
    check("reset_outputs", {w_rd, i_rd, w_valid, i_valid, busy, done}, 0);
    check("reset_tags", {Wsize, stride, wgroup, wround}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_job(2'd0, 1'b0, 4'd2, 16'h0000, 16'h0000);   // 3x3 basic
    run_job(2'd1, 1'b0, 4'd4, 16'h0040, 16'h0300);   // 5x5 rounds
    run_job(2'd0, 1'b1, 4'd1, 16'h1000, 16'h2000);   // 3x3 stride 2
    run_job(2'd3, 1'b0, 4'd0, 16'hFFF8, 16'hFFFC);   // reserved size, passes 0, wrap
    reset_mid_job();
    run_job(2'd1, 1'b1, 4'd3, 16'h0777, 16'h0123);
    for (int n = 0; n < 6; n++)
      run_job(2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
              4'($urandom_range(15, 0)), 16'($urandom), 16'($urandom));

    repeat (4) @(posedge clk);
    #1;
    check("done_count", done_seen, exp_done);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ipf_feeder.md
# ipf_feeder

Sequencer directly upstream of the IPF multiply engine. On a `start` pulse it reads a weight block and then repeated passes of an 8-word input tile from two synchronous on-chip memories. It drives IPF's `w_valid`/`w_data`, `i_valid`/`i_data`, `ctrl`, `Wsize`, `stride`, `wgroup` and `wround` in the exact order IPF expects. After the last pass it issues END and waits for IPF's `finish` before reporting `done`.

## Interface
- `DATA_W`, 64, memory and IPF data word width
- `ADDR_W`, 16, memory address width
- `I_WORDS`, 8, input words per pass
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle job request; ignored while `busy`
- `cfg_wsize`  in  2  0 = 3x3, 1 = 5x5, 2/3 = reserved (treated as 3x3)
- `cfg_stride`  in  1  0 = stride 1, 1 = stride 2
- `cfg_passes`  in  4  number of input passes; 0 is treated as 1
- `cfg_w_base` / `cfg_i_base`  in  ADDR_W  memory base addresses
- `w_rd`, `w_addr`  out  1 / ADDR_W  weight memory read
- `w_rdata`  in  DATA_W  valid one cycle after `w_rd`
- `i_rd`, `i_addr`, `i_rdata`  same, for input memory
- `w_valid`, `w_data`  out  1 / DATA_W  to IPF
- `i_valid`, `i_data`  out  1 / DATA_W  to IPF
- `ctrl`  out  2  0 = END, 1 = START, 2 = HOLD
- `Wsize`  out  2  to IPF
- `stride`  out  1  to IPF
- `wgroup`  out  4  to IPF
- `wround`  out  3  to IPF
- `ipf_finish`  in  1  IPF `finish`
- `busy`  out  1  job in progress
- `done`  out  1  one-cycle pulse when the job completes

## Operation
- **Config capture.** Configuration is sampled only on an accepted `start`.
- **Derived counts.**
  - `NW` = 18 (3x3) or 25 (5x5).
  - `LEAD` = 2 (3x3) or 4 (5x5).
- **States:** IDLE → WLOAD → PASS → ENDW → IDLE.
- **IDLE.** `start` moves to WLOAD.
- **WLOAD.**
  - Issues `NW` consecutive weight reads: `w_addr` = `cfg_w_base` + k, for k = 0..NW-1.
  - On the last read, goes directly to PASS with no bubble.
- **PASS.**
  - For pass p = 0..P-1, issues `I_WORDS` reads: `i_addr` = `cfg_i_base` + j, for j = 0..I_WORDS-1.
  - Tag per word: `ctrl` = HOLD for j < `LEAD`, START otherwise.
  - Passes run back to back.
  - After the last word of pass P-1, goes to ENDW.
- **wgroup / wround per word.**
  - 3x3, stride 1: `wgroup` = p, `wround` = 0.
  - 3x3, stride 2: `wgroup` = j[0] during START words, 0 during HOLD words; `wround` = 0.
  - 5x5: `wround` = p[0], `wgroup` = p>>1.
- **ENDW.**
  - `ctrl` = END, `i_valid` = 0.
  - Waits for `ipf_finish`, then pulses `done` for one cycle and returns to IDLE.
  - `ctrl` stays END until the next job.
- **Side-band outputs.** `Wsize` and `stride` are driven from the captured configuration for the whole job.

## Timing
- **Alignment pipeline.** Every read slot passes through a 2-stage alignment pipe: the memory cycle plus one output register.
- **Data latency.** `w_valid`/`i_valid`/data assert exactly 2 cycles after the matching `*_rd`.
- **Tag latency.** `ctrl`/`wgroup`/`wround` tags travel with the data, so they change on the same edge as `i_valid`/`i_data`.
- **Start latency.** `w_rd` first asserts in the cycle after `start` is sampled.
- **Streaming.** The last `w_valid` is immediately followed by the first `i_valid`. `i_valid` is continuous for P×`I_WORDS` cycles.
- **ipf_finish timing.** `ipf_finish` is sampled only in ENDW, and only after the pipe has drained. An earlier `ipf_finish` is ignored.
- **Busy window.** `busy` rises on the edge that accepts `start` and falls on the edge that asserts `done`.
- **Reset values.** All outputs reset to 0, except `ctrl`, which resets to HOLD (2). State resets to IDLE.
- **Reset mid-job.** Reset aborts the job with no `done`. The pipe is cleared.

## Structure
- **Shared package `ipf_pkg`:**
  - `ctrl` encodings `CTRL_END`/`CTRL_START`/`CTRL_HOLD`.
  - `Wsize` encodings.
  - `NW` constants 18/25 and `LEAD` constants 2/4.
  - State enum.
- **Sub-module `ipf_rd_align`:**
  - 2-stage valid/tag delay line with a data register.
  - Instantiated once for the weight path and once for the input path.

## Test plan
- **3x3 basic.** 3x3, stride 0, passes = 2, bases 0/0 → 18 `w_valid` words from `w_addr` 0..17, then 16 `i_valid` words. Per pass, `ctrl` = H,H,S,S,S,S,S,S. `wgroup` = 0 for pass 0 and 1 for pass 1. `ctrl` = END afterwards; `ipf_finish` → `done` one cycle later.
- **5x5 rounds.** 5x5, passes = 4 → 25 weight words. Per pass, `ctrl` = HHHHSSSS. `wround` sequence per pass = 0,1,0,1; `wgroup` = 0,0,1,1.
- **3x3 stride 2.** 3x3, stride 1, passes = 1 → `wgroup` = 0,0,0,1,0,1,0,1 over the 8 input words.
- **Alignment check.** Memory returns `i_rdata` = address+0xA0 → `i_data` equals the value read 2 cycles earlier. There are no gaps between weight and input streams.
- **Corner cases.**
  - `start` while `busy`: ignored.
  - `ipf_finish` pulsed during PASS: no early `done`.
  - `cfg_passes` = 0: runs one pass.
- **Reset mid-job.** `rst` low during pass 1 → all outputs reset, `ctrl` = 2, no `done`. A new `start` then runs correctly.
